// File: rtl/fp_minmax_prep_if.sv
// ============================================================================
// Module      : fp_minmax_prep_if
// Description : Upstream/downstream handshake and operand bus for fp_minmax_prep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_minmax_prep_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] in_numA;
    logic [DATA_WIDTH-1:0] in_numB;
    logic                  in_ctrl_minmax;
    logic                  out_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_numA;
    logic [DATA_WIDTH-1:0] out_numB;
    logic                  out_ctrl_minmax;
    logic                  out_bypass;
    logic [DATA_WIDTH-1:0] out_bypass_data;
    logic                  out_flag_nv;

    modport master (
        output in_valid, in_numA, in_numB, in_ctrl_minmax, in_ready,
        input  out_ready, out_valid, out_numA, out_numB, out_ctrl_minmax,
               out_bypass, out_bypass_data, out_flag_nv
    );

    modport slave (
        input  in_valid, in_numA, in_numB, in_ctrl_minmax, in_ready,
        output out_ready, out_valid, out_numA, out_numB, out_ctrl_minmax,
               out_bypass, out_bypass_data, out_flag_nv
    );
endinterface

`default_nettype wire

// File: rtl/fp_minmax_prep.sv
// ============================================================================
// Module      : fp_minmax_prep
// Description : Pre-classifies FP min/max operands (NaN, signed zero) and
//               buffers them in a 2-entry FIFO ahead of the comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_minmax_prep #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic          in_clk,
    input  wire logic          in_rst,
    input  wire logic          in_flush,
    fp_minmax_prep_if.slave    bus
);

    localparam int EXP_W = 8;
    localparam int MAN_W = DATA_WIDTH - 1 - EXP_W;
    localparam logic [DATA_WIDTH-1:0] c_canon_nan =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_WIDTH-1:0] num_a;
        logic [DATA_WIDTH-1:0] num_b;
        logic                  ctrl;
        logic                  bypass;
        logic [DATA_WIDTH-1:0] bdata;
        logic                  nv;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    entry_t r_head;
    entry_t r_tail;
    entry_t w_new;

    logic w_push;
    logic w_pop;
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_zero, w_b_zero;

    // Operand classification
    always_comb begin
        w_a_nan  = (&bus.in_numA[DATA_WIDTH-2 -: EXP_W]) && (|bus.in_numA[MAN_W-1:0]);
        w_b_nan  = (&bus.in_numB[DATA_WIDTH-2 -: EXP_W]) && (|bus.in_numB[MAN_W-1:0]);
        w_a_snan = w_a_nan && !bus.in_numA[MAN_W-1];
        w_b_snan = w_b_nan && !bus.in_numB[MAN_W-1];
        w_a_zero = ~|bus.in_numA[DATA_WIDTH-2:0];
        w_b_zero = ~|bus.in_numB[DATA_WIDTH-2:0];
    end

    always_comb begin
        w_new.num_a  = bus.in_numA;
        w_new.num_b  = bus.in_numB;
        w_new.ctrl   = bus.in_ctrl_minmax;
        w_new.bypass = 1'b0;
        w_new.bdata  = '0;
        w_new.nv     = w_a_snan || w_b_snan;
        if (w_a_nan && w_b_nan) begin
            w_new.bypass = 1'b1;
            w_new.bdata  = c_canon_nan;
        end else if (w_a_nan) begin
            w_new.bypass = 1'b1;
            w_new.bdata  = bus.in_numB;
        end else if (w_b_nan) begin
            w_new.bypass = 1'b1;
            w_new.bdata  = bus.in_numA;
        end else if (w_a_zero && w_b_zero &&
                     (bus.in_numA[DATA_WIDTH-1] != bus.in_numB[DATA_WIDTH-1])) begin
            // min picks -0, max picks +0
            w_new.bypass = 1'b1;
            w_new.bdata  = {!bus.in_ctrl_minmax, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    assign bus.out_ready = (r_state != S_TWO);
    assign bus.out_valid = (r_state != S_EMPTY);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush discards any handshake happening in the same cycle
    always_comb begin
        w_push       = bus.in_valid && bus.out_ready && !in_flush;
        w_pop        = bus.out_valid && bus.in_ready && !in_flush;
        w_state_next = r_state;
        if (in_flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push)           w_state_next = S_ONE;
                S_ONE:   if (w_push && !w_pop) w_state_next = S_TWO;
                         else if (!w_push && w_pop) w_state_next = S_EMPTY;
                S_TWO:   if (w_pop)            w_state_next = S_ONE;
                default:                       w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_pop))) begin
                r_head <= w_new;
            end else if (w_pop && (r_state == S_TWO)) begin
                r_head <= r_tail;
            end
            if (w_push && (r_state == S_ONE) && !w_pop) begin
                r_tail <= w_new;
            end
        end
    end

    assign bus.out_numA        = r_head.num_a;
    assign bus.out_numB        = r_head.num_b;
    assign bus.out_ctrl_minmax = r_head.ctrl;
    assign bus.out_bypass      = r_head.bypass;
    assign bus.out_bypass_data = r_head.bdata;
    assign bus.out_flag_nv     = r_head.nv;

endmodule

`default_nettype wire

// File: doc/fp_minmax_prep.md
FP_MINMAX_PREP -- requirements
Module: fp_minmax_prep

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand width (single-precision layout: sign [31], exponent [30:23], mantissa [22:0]).
REQ-002 Port: in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: in_rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_flush  input  1  synchronous flush of all buffered operations.
REQ-005 Port: in_valid  input  1  upstream operation valid.
REQ-006 Port: out_ready  output  1  block can accept an operation this cycle.
REQ-007 Port: in_numA, in_numB  input  DATA_WIDTH  source operands.
REQ-008 Port: in_ctrl_minmax  input  1  1 = max, 0 = min.
REQ-009 Port: out_valid  output  1  head entry valid toward the downstream comparator.
REQ-010 Port: in_ready  input  1  downstream comparator accepts the head entry.
REQ-011 Port: out_numA, out_numB, out_ctrl_minmax  output  DATA_WIDTH/DATA_WIDTH/1  head-entry operands and op.
REQ-012 Port: out_bypass  output  1  head-entry result is already resolved; downstream comparator output is ignored.
REQ-013 Port: out_bypass_data  output  DATA_WIDTH  resolved result, valid when out_bypass=1.
REQ-014 Port: out_flag_nv  output  1  invalid-operation flag for the head entry.

Function
REQ-015 Classification: NaN = exponent all ones and mantissa nonzero; sNaN = NaN and mantissa[22]=0; zero = exponent and mantissa both 0.
REQ-016 Both operands NaN: out_bypass=1, out_bypass_data=32'h7FC00000 (canonical NaN).
REQ-017 Exactly one operand NaN: out_bypass=1, out_bypass_data = the non-NaN operand.
REQ-018 Both zero with opposite signs: out_bypass=1; min yields 32'h80000000, max yields 32'h00000000.
REQ-019 Any other operand pair: out_bypass=0, out_bypass_data=0, operands forwarded unchanged.
REQ-020 out_flag_nv=1 when either operand is sNaN, independent of the bypass outcome; otherwise 0.
REQ-021 Classification is computed at accept time and stored with the entry; no combinational path exists from in_num* to out_* ports.
REQ-022 Storage: 2-entry FIFO; states EMPTY, ONE, TWO, tracked by a 2-bit occupancy count.
REQ-023 Accept (push) occurs when in_valid=1 and out_ready=1; out_ready = (count != 2).
REQ-024 Pop occurs when out_valid=1 and in_ready=1; out_valid = (count != 0).
REQ-025 Latency: an operation accepted into EMPTY is presented on out_* in the following cycle.
REQ-026 Transitions: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged, with the head advancing and the new entry appended.
REQ-027 In TWO, out_ready=0, so a push cannot coincide with a full buffer.
REQ-028 In ONE with push and pop in the same cycle, the new entry becomes the head on the next cycle.
REQ-029 When out_valid=1 and in_ready=0, all out_* values hold stable until a pop occurs.
REQ-030 Ordering is strictly FIFO; no entry is dropped or duplicated.
REQ-031 in_flush=1: next cycle count=0, out_valid=0, and out_ready=1; a push or pop in the flush cycle is discarded.

Reset
REQ-032 in_rst=1: next cycle count=0, out_valid=0, out_ready=1, and all data, bypass and flag outputs are 0.
REQ-033 in_rst takes priority over in_flush, push and pop; reset asserted mid-operation discards all entries.
REQ-034 After in_rst deasserts, the first accept is possible in the same cycle as deassertion.

Verification
REQ-035 Operands A=3F800000, B=40000000, max, in_ready=1: out_valid 1 cycle later, bypass=0, operands forwarded, nv=0.
REQ-036 Operands A=7F800001 (sNaN), B=3F800000, min: bypass=1, data=3F800000, nv=1; A=B=7FC00000: data=7FC00000, nv=0.
REQ-037 Operands A=00000000, B=80000000: min gives 80000000; max gives 00000000; bypass=1 in both cases.
REQ-038 in_ready=0, three back-to-back pushes: out_ready falls after the 2nd push, the 3rd push is held off, outputs stay stable, then drain in order once in_ready=1.
REQ-039 Count=1 with push and pop in the same cycle: count stays 1, the new entry is at the head, no loss.
REQ-040 Count=2, then in_flush or in_rst pulsed: next cycle out_valid=0 and out_ready=1; in_rst additionally zeroes all outputs.
